// File: rtl/ddr_pkg.sv
// Shared types for the DDR3 command-bus tracker: decoded commands, error codes, bank states.
// Also provides the counter-width helper used by the per-bank timers.
package ddr_pkg;

  typedef enum logic [3:0] {
    CMD_DES  = 4'd0,
    CMD_NOP  = 4'd1,
    CMD_ACT  = 4'd2,
    CMD_RD   = 4'd3,
    CMD_WR   = 4'd4,
    CMD_PRE  = 4'd5,
    CMD_PREA = 4'd6,
    CMD_REF  = 4'd7,
    CMD_MRS  = 4'd8,
    CMD_ZQ   = 4'd9
  } ddr_cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_ACT_OPEN  = 3'd1,
    ERR_TRP       = 3'd2,
    ERR_RW_CLOSED = 3'd3,
    ERR_TRCD      = 3'd4,
    ERR_TRAS      = 3'd5,
    ERR_REF_OPEN  = 3'd6
  } ddr_err_e;

  typedef enum logic [1:0] {
    BANK_IDLE    = 2'd0,
    BANK_OPENING = 2'd1,
    BANK_OPEN    = 2'd2,
    BANK_CLOSING = 2'd3
  } bank_state_e;

  // Width needed to hold 0..max; never narrower than one bit.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/ddr_bank_fsm.sv
// One DDR3 bank: IDLE/OPENING/OPEN/CLOSING with tRCD, tRAS and tRP down-counters.
// State updates on the edge that samples act/pre; strobes arrive pre-qualified (no error).
module ddr_bank_fsm
  import ddr_pkg::*;
#(
  parameter int T_RCD = 5,
  parameter int T_RP  = 5,
  parameter int T_RAS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        act,
  input  logic        pre,
  output bank_state_e state,
  output logic        ras_done
);

  localparam int RCD_W = cnt_w(T_RCD - 1);
  localparam int RP_W  = cnt_w(T_RP - 1);
  localparam int RAS_W = cnt_w(T_RAS - 1);

  bank_state_e      state_nxt;
  logic [RCD_W-1:0] rcd, rcd_nxt;
  logic [RP_W-1:0]  rp, rp_nxt;
  logic [RAS_W-1:0] ras, ras_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BANK_IDLE;
      rcd   <= '0;
      rp    <= '0;
      ras   <= '0;
    end else begin
      state <= state_nxt;
      rcd   <= rcd_nxt;
      rp    <= rp_nxt;
      ras   <= ras_nxt;
    end
  end

  // Phase changes fire when a counter is at 1, so the first legal command sees the settled state.
  always_comb begin
    state_nxt = state;
    rcd_nxt   = (rcd != '0) ? rcd - RCD_W'(1) : '0;
    rp_nxt    = (rp != '0) ? rp - RP_W'(1) : '0;
    ras_nxt   = (ras != '0) ? ras - RAS_W'(1) : '0;
    case (state)
      BANK_IDLE: begin
        if (act) begin
          if (T_RCD > 1) state_nxt = BANK_OPENING;
          else           state_nxt = BANK_OPEN;
          rcd_nxt = RCD_W'(T_RCD - 1);
          ras_nxt = RAS_W'(T_RAS - 1);
        end
      end
      BANK_OPENING, BANK_OPEN: begin
        if (pre) begin
          if (T_RP > 1) state_nxt = BANK_CLOSING;
          else          state_nxt = BANK_IDLE;
          rp_nxt = RP_W'(T_RP - 1);
        end else if (state == BANK_OPENING && rcd <= RCD_W'(1)) begin
          state_nxt = BANK_OPEN;
        end
      end
      BANK_CLOSING: begin
        if (rp <= RP_W'(1)) state_nxt = BANK_IDLE;
      end
      default: state_nxt = BANK_IDLE;
    endcase
  end

  assign ras_done = (ras == '0);

endmodule

// File: rtl/ddr_cmd_tracker.sv
// Passive DDR3 command decoder and bank tracker; never drives the bus, no backpressure.
// All outputs appear one clock after the pins are sampled; erroring commands leave bank state untouched.
module ddr_cmd_tracker
  import ddr_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int ROW_W     = 14,
  parameter int T_RCD     = 5,
  parameter int T_RP      = 5,
  parameter int T_RAS     = 15,
  localparam int BA_W     = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 we_n,
  input  logic [BA_W-1:0]      ba,
  input  logic [ROW_W-1:0]     addr,
  output logic [3:0]           cmd_o,
  output logic [BA_W-1:0]      cmd_bank_o,
  output logic [ROW_W-1:0]     cmd_addr_o,
  output logic [NUM_BANKS-1:0] bank_open_o,
  output logic                 err_o,
  output logic [2:0]           err_code_o,
  output logic [BA_W-1:0]      err_bank_o
);

  ddr_cmd_e             cmd_d;
  ddr_err_e             err_d;
  logic [BA_W-1:0]      err_bank_d;
  bank_state_e          bank_st [NUM_BANKS];
  logic [NUM_BANKS-1:0] ras_done;
  logic [NUM_BANKS-1:0] act_stb;
  logic [NUM_BANKS-1:0] pre_stb;

  always_comb begin
    cmd_d = CMD_DES;
    if (cke && !cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b111: cmd_d = CMD_NOP;
        3'b011: cmd_d = CMD_ACT;
        3'b101: cmd_d = CMD_RD;
        3'b100: cmd_d = CMD_WR;
        3'b010: cmd_d = addr[10] ? CMD_PREA : CMD_PRE;
        3'b001: cmd_d = CMD_REF;
        3'b000: cmd_d = CMD_MRS;
        3'b110: cmd_d = CMD_ZQ;
      endcase
    end
  end

  // Downward loops leave the lowest-index offender as the reported bank.
  always_comb begin
    err_d      = ERR_NONE;
    err_bank_d = ba;
    case (cmd_d)
      CMD_ACT: begin
        if (bank_st[ba] == BANK_OPENING || bank_st[ba] == BANK_OPEN) err_d = ERR_ACT_OPEN;
        else if (bank_st[ba] == BANK_CLOSING)                        err_d = ERR_TRP;
      end
      CMD_RD, CMD_WR: begin
        if (bank_st[ba] == BANK_IDLE || bank_st[ba] == BANK_CLOSING) err_d = ERR_RW_CLOSED;
        else if (bank_st[ba] == BANK_OPENING)                        err_d = ERR_TRCD;
      end
      CMD_PRE: begin
        if (!ras_done[ba]) err_d = ERR_TRAS;
      end
      CMD_PREA: begin
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
          if (!ras_done[b]) begin
            err_d      = ERR_TRAS;
            err_bank_d = BA_W'(b);
          end
        end
      end
      CMD_REF: begin
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
          if (bank_st[b] != BANK_IDLE) begin
            err_d      = ERR_REF_OPEN;
            err_bank_d = BA_W'(b);
          end
        end
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : gen_bank
    assign act_stb[g] = (err_d == ERR_NONE) && (cmd_d == CMD_ACT) && (ba == BA_W'(g));
    assign pre_stb[g] = (err_d == ERR_NONE) &&
                        ((cmd_d == CMD_PRE && ba == BA_W'(g)) || cmd_d == CMD_PREA);

    ddr_bank_fsm #(
      .T_RCD(T_RCD),
      .T_RP (T_RP),
      .T_RAS(T_RAS)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .act     (act_stb[g]),
      .pre     (pre_stb[g]),
      .state   (bank_st[g]),
      .ras_done(ras_done[g])
    );

    assign bank_open_o[g] = (bank_st[g] == BANK_OPENING) || (bank_st[g] == BANK_OPEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_o      <= CMD_DES;
      cmd_bank_o <= '0;
      cmd_addr_o <= '0;
      err_o      <= 1'b0;
      err_code_o <= ERR_NONE;
      err_bank_o <= '0;
    end else begin
      cmd_o      <= cmd_d;
      cmd_bank_o <= ba;
      cmd_addr_o <= addr;
      err_o      <= (err_d != ERR_NONE);
      err_code_o <= err_d;
      err_bank_o <= (err_d != ERR_NONE) ? err_bank_d : '0;
    end
  end

endmodule
